// File: rtl/keycode_event_unit.sv
// keycode_event_unit: turns changes of the two-slot HID keycode set into ordered press/release events in a FIFO.
// Optional build macro KEYCODE_STABLE_FILTER_EN inserts a keycode stability filter ahead of the FSM.
module keycode_event_unit #(
    parameter int DEPTH = 8
`ifdef KEYCODE_STABLE_FILTER_EN
    ,
    parameter int STABLE_CYCLES = 4
`endif
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic        evt_release,
    output logic [7:0]  evt_code,
    output logic        held_w,
    output logic        held_a,
    output logic        held_s,
    output logic        held_d,
    output logic        held_space,
    output logic        busy,
    output logic        overflow,
    input  logic        ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_REL0, S_REL1, S_PRS0, S_PRS1} state_t;

    function automatic logic key_in(input logic [7:0] code, input logic [7:0] a, input logic [7:0] b);
        return (code == a) || (code == b);
    endfunction

    // ---------------- input stage ----------------
    logic [15:0] r_kc_q;

`ifdef KEYCODE_STABLE_FILTER_EN
    logic [15:0] r_kc_raw_prev;
    logic [7:0]  r_stable_cnt;

    // A value reaches the FSM only after it has stayed unchanged for STABLE_CYCLES edges.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_kc_raw_prev <= '0;
            r_stable_cnt  <= '0;
            r_kc_q        <= '0;
        end else begin
            r_kc_raw_prev <= keycode;
            if (keycode != r_kc_raw_prev)
                r_stable_cnt <= '0;
            else if (r_stable_cnt != 8'(STABLE_CYCLES))
                r_stable_cnt <= r_stable_cnt + 8'd1;
            if (r_stable_cnt == 8'(STABLE_CYCLES))
                r_kc_q <= r_kc_raw_prev;
        end
    end
`else
    always_ff @(posedge Clk) begin
        if (Reset) r_kc_q <= '0;
        else       r_kc_q <= keycode;
    end
`endif

    // ---------------- normalisation ----------------
    logic [7:0] w_n0, w_n1;
    logic       w_sample_ok, w_same_set;

    assign w_n0        = r_kc_q[7:0];
    assign w_n1        = (r_kc_q[15:8] == r_kc_q[7:0]) ? 8'h00 : r_kc_q[15:8];
    assign w_sample_ok = (r_kc_q[7:0] != 8'h01) && (r_kc_q[15:8] != 8'h01);

    // ---------------- FSM ----------------
    state_t     r_state, w_state_nxt;
    logic [7:0] r_c0, r_c1, r_old0, r_old1, r_new0, r_new1;
    logic [4:0] r_held;
    logic       w_snap, w_commit, w_push;
    logic [8:0] w_push_data;

    assign w_same_set = ((w_n0 == r_c0) && (w_n1 == r_c1)) || ((w_n0 == r_c1) && (w_n1 == r_c0));

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_snap      = 1'b0;
        w_commit    = 1'b0;
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state)
            S_IDLE: begin
                if (w_sample_ok && !w_same_set) begin
                    w_snap      = 1'b1;
                    w_state_nxt = S_REL0;
                end
            end
            S_REL0: begin
                w_push      = (r_old0 != 8'h00) && !key_in(r_old0, r_new0, r_new1);
                w_push_data = {1'b1, r_old0};
                w_state_nxt = S_REL1;
            end
            S_REL1: begin
                w_push      = (r_old1 != 8'h00) && !key_in(r_old1, r_new0, r_new1);
                w_push_data = {1'b1, r_old1};
                w_state_nxt = S_PRS0;
            end
            S_PRS0: begin
                w_push      = (r_new0 != 8'h00) && !key_in(r_new0, r_old0, r_old1);
                w_push_data = {1'b0, r_new0};
                w_state_nxt = S_PRS1;
            end
            S_PRS1: begin
                w_push      = (r_new1 != 8'h00) && !key_in(r_new1, r_old0, r_old1);
                w_push_data = {1'b0, r_new1};
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_c0   <= '0;
            r_c1   <= '0;
            r_old0 <= '0;
            r_old1 <= '0;
            r_new0 <= '0;
            r_new1 <= '0;
            r_held <= '0;
        end else begin
            if (w_snap) begin
                r_new0 <= w_n0;
                r_new1 <= w_n1;
                r_old0 <= r_c0;
                r_old1 <= r_c1;
            end
            if (w_commit) begin
                r_c0   <= r_new0;
                r_c1   <= r_new1;
                r_held <= {key_in(8'h1A, r_new0, r_new1), key_in(8'h04, r_new0, r_new1),
                           key_in(8'h16, r_new0, r_new1), key_in(8'h07, r_new0, r_new1),
                           key_in(8'h2C, r_new0, r_new1)};
            end
        end
    end

    assign {held_w, held_a, held_s, held_d, held_space} = r_held;
    assign busy = (r_state != S_IDLE);

    // ---------------- event FIFO ----------------
    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_full, w_pop, w_do_push, w_drop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign evt_valid = (r_count != '0);
    assign w_pop     = evt_valid && evt_ready;
    assign w_do_push = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // NOTE: storage is not reset; the pointers and count define which entries are live.
    always_ff @(posedge Clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop)       r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    assign {evt_release, evt_code} = evt_valid ? r_mem[r_rd_ptr] : 9'h000;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_keycode_event_unit.sv
// Self-checking bench for keycode_event_unit: set-difference event model with per-cycle compare plus directed literal checks.
`timescale 1ns/1ps
module tb_keycode_event_unit;

    localparam int DEPTH = 8;
`ifdef KEYCODE_STABLE_FILTER_EN
    localparam int STABLE = 4;
    localparam int SETTLE = 9 + STABLE;
`else
    localparam int SETTLE = 8;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] keycode = 16'h0000;
    logic        evt_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        evt_valid, evt_release, busy, overflow;
    logic [7:0]  evt_code;
    logic        held_w, held_a, held_s, held_d, held_space;

    always #5 Clk = ~Clk;

    keycode_event_unit #(
        .DEPTH(DEPTH)
`ifdef KEYCODE_STABLE_FILTER_EN
        , .STABLE_CYCLES(STABLE)
`endif
    ) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_release(evt_release), .evt_code(evt_code),
        .held_w(held_w), .held_a(held_a), .held_s(held_s), .held_d(held_d), .held_space(held_space),
        .busy(busy), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Committed key set kept as two slots; a detected change becomes a list of
    // up to four candidate events (released old keys, then newly pressed keys),
    // emitted one per cycle into a queue modelling the FIFO.
    logic [8:0]       m_q[$];
    logic [15:0]      m_kc;
    logic [1:0][7:0]  m_c, m_new;
    logic [8:0]       m_sched[4];
    bit               m_sched_v[4];
    int               m_phase;
    bit               m_ovf, m_live;
    bit               m_pop, m_push, m_full, m_drop;
    logic [8:0]       m_pd;
    logic [7:0]       m_lo, m_hi;
`ifdef KEYCODE_STABLE_FILTER_EN
    logic [15:0]      m_prev;
    int               m_run;
`endif

    function automatic bit member(input logic [7:0] x, input logic [1:0][7:0] s);
        return (x == s[0]) || (x == s[1]);
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_q.delete();
            m_kc = '0; m_c = '0; m_new = '0; m_phase = 0; m_ovf = 0; m_live = 1;
`ifdef KEYCODE_STABLE_FILTER_EN
            m_prev = '0; m_run = 0;
`endif
        end else begin
            m_pop  = (m_q.size() != 0) && evt_ready;
            m_push = (m_phase >= 1) && m_sched_v[m_phase-1];
            m_pd   = (m_phase >= 1) ? m_sched[m_phase-1] : 9'h0;
            m_full = (m_q.size() == DEPTH);
            m_drop = m_push && m_full && !m_pop;
            if (m_pop) void'(m_q.pop_front());
            if (m_push && !m_drop) m_q.push_back(m_pd);
            if (m_drop) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;

            if (m_phase == 4) begin
                m_c = m_new;
                m_phase = 0;
            end else if (m_phase > 0) begin
                m_phase++;
            end else begin
                m_lo = m_kc[7:0];
                m_hi = (m_kc[15:8] == m_kc[7:0]) ? 8'h00 : m_kc[15:8];
                if (m_kc[7:0] != 8'h01 && m_kc[15:8] != 8'h01 &&
                    !((m_lo == m_c[0] && m_hi == m_c[1]) || (m_lo == m_c[1] && m_hi == m_c[0]))) begin
                    m_new = {m_hi, m_lo};
                    for (int i = 0; i < 2; i++) begin
                        m_sched_v[i]   = (m_c[i] != 0) && !member(m_c[i], m_new);
                        m_sched[i]     = {1'b1, m_c[i]};
                        m_sched_v[2+i] = (m_new[i] != 0) && !member(m_new[i], m_c);
                        m_sched[2+i]   = {1'b0, m_new[i]};
                    end
                    m_phase = 1;
                end
            end

`ifdef KEYCODE_STABLE_FILTER_EN
            if (m_run == STABLE) m_kc = m_prev;
            if (keycode == m_prev) begin
                if (m_run < STABLE) m_run++;
            end else begin
                m_run = 0;
            end
            m_prev = keycode;
`else
            m_kc = keycode;
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (m_live) begin
            check("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) check("evt_head", 32'({evt_release, evt_code}), 32'(m_q[0]));
            check("held", 32'({held_w, held_a, held_s, held_d, held_space}),
                  32'({member(8'h1A, m_c), member(8'h04, m_c), member(8'h16, m_c),
                       member(8'h07, m_c), member(8'h2C, m_c)}));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // Events the consumer actually accepted.
    logic [8:0] dut_log[$];
    always @(negedge Clk) begin
        if (!Reset && evt_valid && evt_ready) dut_log.push_back({evt_release, evt_code});
    end

    function automatic logic [8:0] log_at(input int k);
        return (dut_log.size() > k) ? dut_log[k] : 9'h1FF;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    bit busy_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        step(2);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_held", 32'({held_w, held_a, held_s, held_d, held_space}), 0);
        Reset = 1'b0;
        step(1);

        // Press W.
        evt_ready = 1'b1;
        dut_log.delete();
        keycode = 16'h001A;
`ifndef KEYCODE_STABLE_FILTER_EN
        step(2);
        check("w_e1_busy", 32'(busy), 1);
        step(3);
        check("w_e4_valid", 32'(evt_valid), 1);
        check("w_e4_head", 32'({evt_release, evt_code}), 32'h01A);
        check("w_e4_held", 32'(held_w), 0);
        step(1);
        check("w_e5_held", 32'(held_w), 1);
        check("w_e5_idle", 32'(busy), 0);
`endif
        step(SETTLE);
        check("w_count", dut_log.size(), 1);
        check("w_evt", 32'(log_at(0)), 32'h01A);

        // W released, A and D pressed; the release appears first, at E2.
        dut_log.delete();
        keycode = 16'h0704;
`ifndef KEYCODE_STABLE_FILTER_EN
        step(2);
        check("ad_e1_empty", 32'(evt_valid), 0);
        step(1);
        check("ad_e2_valid", 32'(evt_valid), 1);
        check("ad_e2_head", 32'({evt_release, evt_code}), 32'h11A);
`endif
        step(SETTLE);
        check("ad_count", dut_log.size(), 3);
        check("ad_evt0", 32'(log_at(0)), 32'h11A);
        check("ad_evt1", 32'(log_at(1)), 32'h004);
        check("ad_evt2", 32'(log_at(2)), 32'h007);
        check("ad_held", 32'({held_w, held_a, held_d}), 32'b011);

        // Swapped slots: same set, nothing happens.
        dut_log.delete();
        keycode = 16'h0407;
        busy_seen = 0;
        for (int i = 0; i < SETTLE; i++) begin
            step(1);
            busy_seen |= busy;
        end
        check("swap_busy", 32'(busy_seen), 0);
        check("swap_count", dut_log.size(), 0);

        // ErrorRollOver ignored, duplicate slots collapse to one key.
        keycode = 16'h0000;
        step(SETTLE);
        dut_log.delete();
        keycode = 16'h0101;
        step(SETTLE);
        check("ero_count", dut_log.size(), 0);
        keycode = 16'h2C2C;
        step(SETTLE);
        check("dup_count", dut_log.size(), 1);
        check("dup_evt", 32'(log_at(0)), 32'h02C);
        check("dup_held", 32'(held_space), 1);

        // Overflow: nine events into an eight-entry FIFO with no consumer.
        keycode = 16'h0000;
        step(SETTLE);
        evt_ready = 1'b0;
        dut_log.delete();
        for (int i = 0; i < 9; i++) begin
            keycode = (i % 2 == 0) ? 16'h001A : 16'h0000;
            step(SETTLE);
        end
        check("ovf_valid", 32'(evt_valid), 1);
        check("ovf_flag", 32'(overflow), 1);
        evt_ready = 1'b1;
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 0);
        step(12);
        check("drain_count", dut_log.size(), 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("drain_evt%0d", k), 32'(log_at(k)), (k % 2 == 0) ? 32'h01A : 32'h11A);

        // Reset in the middle of a sequence.
        dut_log.delete();
        keycode = 16'h0000;
        step(2);
        Reset = 1'b1;
        step(1);
        check("mid_rst_valid", 32'(evt_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_held", 32'(held_w), 0);
        Reset = 1'b0;
        step(SETTLE);
        check("mid_rst_count", dut_log.size(), 0);

`ifdef KEYCODE_STABLE_FILTER_EN
        // Short glitch filtered out; a held value gets through.
        dut_log.delete();
        keycode = 16'h0016;
        step(2);
        keycode = 16'h0000;
        step(SETTLE);
        check("glitch_count", dut_log.size(), 0);
        keycode = 16'h0016;
        step(6);
        step(SETTLE);
        check("stable_count", dut_log.size(), 1);
        check("stable_evt", 32'(log_at(0)), 32'h016);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
